// File: rtl/fetch_pkg.sv
// fetch_pkg: shared fetch/decode types -- FSM states, NOP value and the IF/ID record
package fetch_pkg;
    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0000;
    typedef enum logic [1:0] {REQ = 2'd0, HOLD = 2'd1, DRAIN = 2'd2} state_t;
    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc_plus4;
        logic            valid;
    } if_id_t;
endpackage

// File: rtl/fetch_skid_entry.sv
// fetch_skid_entry: one-entry {instr, pc_plus4} store with load/clear and valid flag
//   clk, rst (async active-low), load/clear controls, din_* data in, valid/instr/pc_plus4 out
module fetch_skid_entry #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         clear,
    input  logic [W-1:0] din_instr,
    input  logic [W-1:0] din_pc,
    output logic         valid,
    output logic [W-1:0] instr,
    output logic [W-1:0] pc_plus4
);
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid    <= 1'b0;
            instr    <= '0;
            pc_plus4 <= '0;
        end else if (clear) begin
            valid <= 1'b0;
        end else if (load) begin
            valid    <= 1'b1;
            instr    <= din_instr;
            pc_plus4 <= din_pc;
        end
    end
endmodule

// File: rtl/fetch_decode_buffer.sv
// fetch_decode_buffer: imem req/ack handshake, IF/ID register and skid buffer
//   clk, rst (async active-low); PCF/PCPlus4F from fetch; StallD/FlushD from hazard unit
//   imem_req/imem_addr/imem_ack/imem_rdata memory port; FetchBusy to StallF
//   InstrD/PCPlus4D/ValidD registered outputs to decode
module fetch_decode_buffer
    import fetch_pkg::*;
#(
    parameter int          N   = XLEN,
    parameter logic [31:0] NOP = NOP_INSTR
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] PCF,
    input  logic [N-1:0] PCPlus4F,
    input  logic         StallD,
    input  logic         FlushD,
    output logic         imem_req,
    output logic [N-1:0] imem_addr,
    input  logic         imem_ack,
    input  logic [N-1:0] imem_rdata,
    output logic         FetchBusy,
    output logic [N-1:0] InstrD,
    output logic [N-1:0] PCPlus4D,
    output logic         ValidD
);
    state_t       state, state_n;
    if_id_t       if_id;
    logic [N-1:0] drain_pc;
    logic [N-1:0] skid_instr, skid_pc;
    logic         skid_valid, skid_load, skid_clear, illegal, ld_mem, ld_skid;

    assign illegal    = !(state == REQ || state == HOLD || state == DRAIN);
    assign ld_mem     = state == REQ && imem_ack && !StallD;
    assign ld_skid    = state == HOLD && !StallD && skid_valid;
    assign skid_load  = state == REQ && imem_ack && StallD && !FlushD;
    assign skid_clear = (state == HOLD && (FlushD || !StallD)) || illegal;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= REQ;
        else state <= state_n;
    end

    always_comb begin
        state_n = REQ;
        case (state)
            REQ:     state_n = imem_ack ? ((FlushD || !StallD) ? REQ : HOLD) : (FlushD ? DRAIN : REQ);
            HOLD:    state_n = (FlushD || !StallD) ? REQ : HOLD;
            DRAIN:   state_n = imem_ack ? REQ : DRAIN;
            default: state_n = REQ;
        endcase
    end

    // A flush without ack releases fetch so it can take the redirect; the
    // orphaned request is retired from drain_pc in DRAIN.
    always_comb begin
        imem_req  = rst && (state == REQ || state == DRAIN);
        imem_addr = (state == DRAIN) ? drain_pc : PCF;
        FetchBusy = (state == REQ) ? (!imem_ack && !FlushD) : 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) drain_pc <= '0;
        else if (state == REQ && !imem_ack && FlushD) drain_pc <= PCF;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) if_id <= '{instr: NOP, pc_plus4: '0, valid: 1'b0};
        else if (FlushD) if_id <= '{instr: NOP, pc_plus4: '0, valid: 1'b0};
        else if (ld_mem) if_id <= '{instr: imem_rdata, pc_plus4: PCPlus4F, valid: 1'b1};
        else if (ld_skid) if_id <= '{instr: skid_instr, pc_plus4: skid_pc, valid: 1'b1};
    end

    fetch_skid_entry #(.W(N)) u_skid (
        .clk       (clk),
        .rst       (rst),
        .load      (skid_load),
        .clear     (skid_clear),
        .din_instr (imem_rdata),
        .din_pc    (PCPlus4F),
        .valid     (skid_valid),
        .instr     (skid_instr),
        .pc_plus4  (skid_pc)
    );

    assign InstrD   = if_id.instr;
    assign PCPlus4D = if_id.pc_plus4;
    assign ValidD   = if_id.valid;
endmodule

// File: doc/fetch_decode_buffer.md
Name: fetch_decode_buffer

Overview:
- Sits between the fetch stage and decode; owns the instruction-memory request handshake and the IF/ID pipeline register.
- Drives the instruction memory from PCF and supports variable-latency memory through a req/ack handshake.
- Raises FetchBusy to the hazard unit, which ORs it into StallF.
- Presents InstrD/PCPlus4D/ValidD to decode, with a one-entry skid buffer that absorbs a returning instruction while decode is stalled.

Parameters:
- N, 32, datapath/address width.
- NOP, 32'h0000_0000, instruction value presented when ValidD=0.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous reset, active-low.
- PCF  input  N  current fetch PC from fetch stage.
- PCPlus4F  input  N  PCF+4 from fetch stage.
- StallD  input  1  hold IF/ID contents.
- FlushD  input  1  invalidate IF/ID (branch taken / PC-from-result).
- imem_req  output  1  instruction memory request.
- imem_addr  output  N  instruction memory address.
- imem_ack  input  1  one-cycle pulse; imem_rdata valid this cycle.
- imem_rdata  input  N  fetched instruction.
- FetchBusy  output  1  fetch must stall (to hazard unit / StallF).
- InstrD  output  N  instruction to decode.
- PCPlus4D  output  N  PC+4 of InstrD.
- ValidD  output  1  InstrD is a real instruction.

Behaviour:
- Reset (rst=0, async):
  - State=REQ; InstrD=NOP, PCPlus4D=0, ValidD=0; skid invalid, skid contents 0; drain_pc=0.
  - imem_req forced 0 while rst=0.
- Memory protocol:
  - imem_addr must stay stable while imem_req=1 until the ack cycle.
  - imem_ack may arrive in the same cycle as the request (zero-wait memory), giving 1 instruction/cycle; otherwise after any number of cycles.
  - At most one request outstanding.
- State REQ: imem_req=1, imem_addr=PCF, FetchBusy=!imem_ack. Priority within a cycle is FlushD > StallD.
  - ack & FlushD: discard rdata; IF/ID <= NOP/0/invalid; stay REQ.
  - ack & !StallD: IF/ID <= {imem_rdata, PCPlus4F, 1}; stay REQ.
  - ack & StallD: IF/ID holds; skid <= {imem_rdata, PCPlus4F}, valid; go HOLD.
  - !ack & FlushD: IF/ID invalidated; drain_pc <= PCF; FetchBusy forced 0 this cycle so fetch takes the redirect; go DRAIN.
  - !ack & !FlushD: IF/ID follows StallD only (hold).
- State HOLD: imem_req=0, FetchBusy=1.
  - FlushD: skid discarded, IF/ID invalidated, go REQ.
  - !StallD: IF/ID <= skid, skid invalid, go REQ.
  - StallD: hold.
- State DRAIN: imem_req=1, imem_addr=drain_pc, FetchBusy=1.
  - On ack: rdata discarded, go REQ.
  - FlushD in DRAIN: IF/ID invalidated, stay DRAIN.
- Flush vs stall: FlushD always clears ValidD and InstrD to NOP, even when StallD=1.
- Latency: the instruction appears on InstrD the cycle after its ack when decode is not stalled.
- PCPlus4D is captured from PCPlus4F at the ack cycle, which is valid because PCF is held until ack; no internal adder.
- Outputs InstrD/PCPlus4D/ValidD are registered. imem_req, imem_addr and FetchBusy are combinational from state and inputs.
- Illegal state encoding: recover to REQ with skid invalid.

Decomposition:
- Package fetch_pkg:
  - state enum {REQ, HOLD, DRAIN}.
  - NOP constant.
  - typedef if_id_t {instr, pc_plus4, valid}, shared with decode.
- Sub-module fetch_skid_entry: one-entry {instr, pc_plus4} store with load/clear and a valid flag, async active-low reset.
- IF/ID register and FSM live in the top.

Test Plan:
- Zero-wait memory (ack tied to req), PCF=0,4,8, rdata=0xA0,0xA4,0xA8 -> InstrD 0xA0,0xA4,0xA8 on consecutive cycles; PCPlus4D=4,8,C; FetchBusy never 1.
- Two-cycle-latency memory, PCF=0x10 -> FetchBusy=1 for one cycle and 0 on the ack cycle; InstrD=rdata and PCPlus4D=0x14 one cycle after ack; imem_addr stable at 0x10 throughout.
- Ack for PCF=0x20 while StallD=1 for 3 cycles -> HOLD, imem_req=0, FetchBusy=1; InstrD shows the skid value the cycle after StallD falls; next request issued.
- FlushD while waiting for the ack of 0x30 -> FetchBusy=0 that cycle, then DRAIN with imem_addr=0x30; late ack data never appears; ValidD=0 until the next real fetch.
- FlushD and StallD together with ValidD=1 -> ValidD=0, InstrD=NOP the next cycle.
- rst asserted low mid-wait with imem_req=1 -> immediate InstrD=NOP, ValidD=0, imem_req=0; after release REQ resumes at PCF=0.
